dff_syn: RTL and testbench



---
 rtl/dff_syn_pkg.sv | 10 +
 rtl/dff_syn_stage.sv | 19 +
 rtl/dff_syn.sv | 58 +++++
 tb/tb_dff_syn.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dff_syn_pkg.sv
// Shared constants and types for the dff_syn retiming register.
// The SVA checks are compiled in only when DFF_SYN_ASSERT_EN is defined.
package dff_syn_pkg;

  localparam int unsigned DFF_SYN_MAX_DEPTH = 7;
  localparam int unsigned DFF_SYN_DEF_WIDTH = 8;

  typedef logic [DFF_SYN_DEF_WIDTH-1:0] dff_syn_word_t;

endpackage

// File: rtl/dff_syn_stage.sv
// One WIDTH-bit register stage with synchronous active-high clear to RESET_VAL.
module dff_syn_stage
  import dff_syn_pkg::*;
#(
  parameter int unsigned          WIDTH     = DFF_SYN_DEF_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/dff_syn.sv
// Parameterizable synchronous-reset delay line: DEPTH chained register stages.
// Defining DFF_SYN_ASSERT_EN compiles in SVA checks; function is unchanged.
module dff_syn
  import dff_syn_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_SYN_DEF_WIDTH,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_in  [DEPTH];
  logic [WIDTH-1:0] stage_out [DEPTH];

  assign stage_in[0] = d;

  // Each stage feeds the next; q is the last stage register itself.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign stage_in[i] = stage_out[i-1];
    end
    dff_syn_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .d     (stage_in[i]),
      .q     (stage_out[i])
    );
  end

  assign q = stage_out[DEPTH-1];

`ifdef DFF_SYN_ASSERT_EN
  if (DEPTH < 1 || DEPTH > DFF_SYN_MAX_DEPTH) begin : g_depth_chk
    $error("dff_syn: DEPTH out of range");
  end

  logic seen_reset;

  always_ff @(posedge clk) begin
    if (reset) seen_reset <= 1'b1;
    else if (seen_reset !== 1'b1) seen_reset <= 1'b0;
  end

  a_reset_val: assert property (@(posedge clk) reset |=> (q == RESET_VAL));

  a_delay: assert property (@(posedge clk) (!reset) [*DEPTH] |=> (q == $past(d, DEPTH)));

  a_no_x: assert property (@(posedge clk) (seen_reset === 1'b1) |-> !$isunknown(q));
`endif

endmodule

// File: tb/tb_dff_syn.sv
// Self-checking bench: three dff_syn instances against a history-based reference model.
module tb_dff_syn;

  logic       clk;
  logic       run;
  logic       rst  [3];
  logic [7:0] din  [3];
  logic [7:0] qo   [3];

  int         total;
  int         bad;
  int         e;
  int         lastr [3];
  int         dep   [3];
  logic [7:0] rv    [3];
  logic [7:0] dh    [3][0:1023];

  dff_syn #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
    .clk(clk), .reset(rst[0]), .d(din[0]), .q(qo[0]));
  dff_syn #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_d3 (
    .clk(clk), .reset(rst[1]), .d(din[1]), .q(qo[1]));
  dff_syn #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_rv (
    .clk(clk), .reset(rst[2]), .d(din[2]), .q(qo[2]));

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (run) clk = ~clk;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected q after an edge: RESET_VAL if flushed within the last DEPTH edges,
  // otherwise the input sampled DEPTH-1 edges ago.
  task automatic tick(input string tag);
    logic [7:0] exp;
    @(posedge clk);
    e++;
    for (int i = 0; i < 3; i++) begin
      dh[i][e] = din[i];
      if (rst[i]) lastr[i] = e;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (lastr[i] >= 0) begin
        if (rst[i] || (e - lastr[i]) < dep[i]) exp = rv[i];
        else exp = dh[i][e - dep[i] + 1];
        check($sformatf("%s_u%0d_e%0d", tag, i, e), qo[i], exp);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; e = 0; run = 1'b1;
    dep[0] = 1; dep[1] = 3; dep[2] = 3;
    rv[0] = 8'h00; rv[1] = 8'h00; rv[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      lastr[i] = -1; rst[i] = 1'b1; din[i] = 8'h00;
    end
    din[0] = 8'hA5;
    #2;
    tick("init_rst");
    check("rst_q_d1", qo[0], 8'h00);
    check("rst_q_rv", qo[2], 8'h5A);

    // DEPTH=1 release and capture
    rst[0] = 1'b0; din[0] = 8'h01;
    tick("d1_rel");
    check("d1_first", qo[0], 8'h01);
    din[0] = 8'h77;
    tick("d1_77");

    // Clock held idle: d and reset wiggle, q must not move
    @(negedge clk);
    run = 1'b0;
    din[0] = 8'h01;
    rst[0] = 1'b1; #7; rst[0] = 1'b0; #20;
    check("idle_hold", qo[0], 8'h77);
    run = 1'b1;
    tick("d1_resume");
    check("d1_after_idle", qo[0], 8'h01);

    // Reset beats data at the same edge
    rst[0] = 1'b1; din[0] = 8'hFF;
    tick("d1_rstwin");
    check("rst_wins", qo[0], 8'h00);
    rst[0] = 1'b0;

    // DEPTH=3 stream from reset release
    rst[1] = 1'b1; tick("d3_rst");
    rst[1] = 1'b0;
    din[1] = 8'h10; tick("d3_s0"); check("d3_q0", qo[1], 8'h00);
    din[1] = 8'h20; tick("d3_s1"); check("d3_q1", qo[1], 8'h00);
    din[1] = 8'h30; tick("d3_s2"); check("d3_q2", qo[1], 8'h10);
    din[1] = 8'h41; tick("d3_s3"); check("d3_q3", qo[1], 8'h20);
    din[1] = 8'h42; tick("d3_s4"); check("d3_q4", qo[1], 8'h30);

    // DEPTH=3 flush while 8'h20/8'h30 are in flight
    rst[1] = 1'b1; tick("fl_rst");
    rst[1] = 1'b0;
    din[1] = 8'h10; tick("fl_a");
    din[1] = 8'h20; tick("fl_b");
    din[1] = 8'h30; tick("fl_c"); check("fl_q10", qo[1], 8'h10);
    rst[1] = 1'b1; din[1] = 8'h00; tick("fl_hit"); check("flush", qo[1], 8'h00);
    rst[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick("fl_drain");
      check($sformatf("flush_clear%0d", k), qo[1], 8'h00);
    end

    // Random traffic; instance 2 never resets here so it stays a pure delay
    for (int k = 0; k < 150; k++) begin
      rst[0] = ($urandom_range(15) == 0);
      rst[1] = ($urandom_range(15) == 0);
      rst[2] = 1'b0;
      for (int i = 0; i < 3; i++) din[i] = 8'($urandom);
      tick("rand");
    end
    rst[2] = 1'b1; tick("rv_rst2");
    check("rv_rst_again", qo[2], 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
